reset_sequencer: RTL and testbench

Parametrised board-level reset and bring-up controller sitting between the clock wizard's `locked` output and the cores instantiated in the board top.
- Synchronises and filters PLL lock.
- Releases NUM_DOMAINS reset outputs in order, with a fixed gap between each.
- Re-asserts all of them on lock loss or on a software request.
- Exposes a lock-loss counter and a heartbeat for the board LEDs.

This replaces the single `reset = !locked` derivation.

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int LOSS_CNT_W = 8;

   // Heartbeat is the top bit of its free-running counter.
   function automatic int hb_msb(input int width);
      return width - 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high clear.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: filters PLL lock, releases domain resets in order,
// re-asserts them all on lock loss or software request.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int LOCK_FILTER = 1024,
   parameter int STAGE_GAP   = 16,
   parameter int HB_WIDTH    = 26
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   locked_in,
   input  logic                   sw_reset,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   ready,
   output logic [1:0]             state,
   output logic [LOSS_CNT_W-1:0]  lock_loss_count,
   output logic                   heartbeat
);

   localparam int FW     = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam int SW     = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int IW     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam int HB_MSB = hb_msb(HB_WIDTH);

   localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
   localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);

   logic locked_s;

   state_t                  state_q, state_d;
   logic [FW-1:0]           filt_q, filt_d;
   logic [SW-1:0]           stage_q, stage_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_DOMAINS-1:0]  rst_q, rst_d;
   logic                    ready_q, ready_d;
   logic [HB_WIDTH-1:0]     hb_q, hb_d;
   logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

   sync_2ff u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (locked_in),
      .q     (locked_s)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= HOLD;
         filt_q  <= '0;
         stage_q <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         hb_q    <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         stage_q <= stage_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         hb_q    <= hb_d;
         loss_q  <= loss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      filt_d  = filt_q;
      stage_d = stage_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      hb_d    = hb_q;
      loss_d  = loss_q;

      unique case (state_q)
         HOLD: begin
            if (sw_reset || !locked_s) begin
               filt_d = '0;
            end else if (filt_q == FILT_LAST) begin
               filt_d   = '0;
               stage_d  = '0;
               rst_d[0] = 1'b0;
               if (NUM_DOMAINS == 1) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = RELEASE;
                  idx_d   = IW'(1);
               end
            end else begin
               filt_d = filt_q + FW'(1);
            end
         end

         RELEASE, RUN: begin
            if (!locked_s || sw_reset) begin
               // Lock loss wins over a coincident sw_reset, so it is counted once.
               state_d = HOLD;
               rst_d   = '1;
               ready_d = 1'b0;
               filt_d  = '0;
               stage_d = '0;
               idx_d   = '0;
               hb_d    = '0;
               if (!locked_s && (loss_q != '1))
                  loss_d = loss_q + LOSS_CNT_W'(1);
            end else if (state_q == RUN) begin
               hb_d = hb_q + HB_WIDTH'(1);
            end else if (stage_q == STAGE_LAST) begin
               stage_d = '0;
               for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                  if (IW'(i) == idx_q)
                     rst_d[i] = 1'b0;
               end
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               stage_d = stage_q + SW'(1);
            end
         end

         default: begin
            state_d = HOLD;
            rst_d   = '1;
            ready_d = 1'b0;
         end
      endcase
   end

   assign rst_out         = rst_q;
   assign ready           = ready_q;
   assign state           = state_q;
   assign lock_loss_count = loss_q;
   assign heartbeat       = hb_q[HB_MSB];

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timestamp-based reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_reset_sequencer;

   localparam int ND  = 3;
   localparam int LF  = 8;
   localparam int GAP = 4;
   localparam int HBW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          locked_in = 1'b0;
   logic          sw_reset = 1'b0;
   logic [ND-1:0] rst_out;
   logic          ready;
   logic [1:0]    state;
   logic [7:0]    lock_loss_count;
   logic          heartbeat;

   int tests = 0;
   int fails = 0;

   reset_sequencer #(
      .NUM_DOMAINS (ND),
      .LOCK_FILTER (LF),
      .STAGE_GAP   (GAP),
      .HB_WIDTH    (HBW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .locked_in       (locked_in),
      .sw_reset        (sw_reset),
      .rst_out         (rst_out),
      .ready           (ready),
      .state           (state),
      .lock_loss_count (lock_loss_count),
      .heartbeat       (heartbeat)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [ND-1:0] rst;
      logic          rdy;
      logic [1:0]    st;
      logic [7:0]    cnt;
      logic          hb;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: lock is seen two edges late; a released sequence is
   // described only by the edge at which domain 0 came out of reset.
   logic pipe[$];
   int   m_edge   = 0;
   bit   m_active = 0;
   int   m_rel    = 0;
   int   m_run    = 0;
   int   m_hb     = 0;
   int   m_loss   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   task automatic step(input logic l, input logic s, input logic r);
      exp_t e;
      logic ls;
      int   elapsed;
      @(negedge clock);
      locked_in = l;
      sw_reset  = s;
      reset     = r;
      m_edge++;
      if (r) begin
         pipe     = {1'b0, 1'b0};
         m_active = 0;
         m_run    = 0;
         m_hb     = 0;
         m_loss   = 0;
      end else begin
         ls = pipe.pop_front();
         pipe.push_back(l);
         if (m_active) begin
            if (!ls || s) begin
               m_active = 0;
               m_run    = 0;
               m_hb     = 0;
               if (!ls && m_loss < 255) m_loss++;
            end else if (m_edge > m_rel + (ND - 1) * GAP) begin
               m_hb = (m_hb + 1) % (1 << HBW);
            end
         end else begin
            if (s || !ls) m_run = 0;
            else if (m_run == LF - 1) begin
               m_active = 1;
               m_rel    = m_edge;
               m_run    = 0;
            end else m_run++;
         end
      end
      if (!m_active) begin
         e.rst = '1;
         e.rdy = 1'b0;
         e.st  = 2'd0;
      end else begin
         elapsed = m_edge - m_rel;
         for (int i = 0; i < ND; i++) e.rst[i] = (elapsed < i * GAP);
         e.rdy = (elapsed >= (ND - 1) * GAP);
         e.st  = e.rdy ? 2'd2 : 2'd1;
      end
      e.cnt = 8'(m_loss);
      e.hb  = ((m_hb >> (HBW - 1)) & 1) != 0;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int n, input logic l, input logic s);
      for (int i = 0; i < n; i++) step(l, s, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rst_out", 32'(rst_out), 32'(e.rst));
            check("ready", 32'(ready), 32'(e.rdy));
            check("state", 32'(state), 32'(e.st));
            check("lock_loss_count", 32'(lock_loss_count), 32'(e.cnt));
            check("heartbeat", 32'(heartbeat), 32'(e.hb));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic l;
      pipe = {1'b0, 1'b0};

      repeat (3) step(1'b0, 1'b0, 1'b1);
      check("reset_rst", 32'(rst_out), 32'h7);
      check("reset_state", 32'(state), 32'd0);
      check("reset_count", 32'(lock_loss_count), 32'd0);
      run(5, 1'b0, 1'b0);

      // Bring-up
      run(9, 1'b1, 1'b0);  check("bringup_hold", 32'(rst_out), 32'b111);
      run(1, 1'b1, 1'b0);  check("bringup_d0", 32'(rst_out), 32'b110);
      run(4, 1'b1, 1'b0);  check("bringup_d1", 32'(rst_out), 32'b100);
      run(4, 1'b1, 1'b0);  check("bringup_d2", 32'(rst_out), 32'b000);
      check("bringup_ready", 32'(ready), 32'd1);
      check("bringup_state", 32'(state), 32'd2);
      run(10, 1'b1, 1'b0);

      // Lock loss in RUN
      run(2, 1'b0, 1'b0);  check("loss_latency", 32'(rst_out), 32'b000);
      run(1, 1'b0, 1'b0);  check("loss_rst", 32'(rst_out), 32'b111);
      check("loss_state", 32'(state), 32'd0);
      check("loss_count", 32'(lock_loss_count), 32'd1);
      check("loss_hb", 32'(heartbeat), 32'd0);
      run(7, 1'b0, 1'b0);
      run(9, 1'b1, 1'b0);  check("relock_hold", 32'(rst_out), 32'b111);
      run(1, 1'b1, 1'b0);  check("relock_d0", 32'(rst_out), 32'b110);
      run(8, 1'b1, 1'b0);  check("relock_ready", 32'(ready), 32'd1);
      run(5, 1'b1, 1'b0);

      // Software reset in RUN
      step(1'b1, 1'b1, 1'b0);
      check("sw_rst", 32'(rst_out), 32'b111);
      check("sw_count", 32'(lock_loss_count), 32'd1);
      run(7, 1'b1, 1'b0);  check("sw_hold", 32'(rst_out), 32'b111);
      run(1, 1'b1, 1'b0);  check("sw_d0", 32'(rst_out), 32'b110);
      run(8, 1'b1, 1'b0);  check("sw_ready", 32'(ready), 32'd1);

      // Glitch filter
      run(8, 1'b0, 1'b0);
      run(5, 1'b1, 1'b0);
      run(1, 1'b0, 1'b0);
      run(9, 1'b1, 1'b0);  check("glitch_hold", 32'(rst_out), 32'b111);
      run(1, 1'b1, 1'b0);  check("glitch_d0", 32'(rst_out), 32'b110);

      // Reset mid-RELEASE
      run(4, 1'b1, 1'b0);  check("midrel_d1", 32'(rst_out), 32'b100);
      step(1'b1, 1'b0, 1'b1);
      check("midrel_rst", 32'(rst_out), 32'b111);
      check("midrel_state", 32'(state), 32'd0);
      check("midrel_count", 32'(lock_loss_count), 32'd0);
      run(9, 1'b1, 1'b0);  check("restart_hold", 32'(rst_out), 32'b111);
      run(1, 1'b1, 1'b0);  check("restart_d0", 32'(rst_out), 32'b110);
      run(8, 1'b1, 1'b0);  check("restart_ready", 32'(ready), 32'd1);

      // Coincident lock loss and sw_reset, driving the counter into saturation
      for (int n = 0; n < 260; n++) begin
         run(2, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0);
         run(10, 1'b1, 1'b0);
      end
      check("saturated_count", 32'(lock_loss_count), 32'd255);

      // Randomised traffic
      l = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 39) == 0) l = ~l;
         step(l, 1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 499) == 0));
      end

      for (int w = 0; w < 5 && exp_q.size() != 0; w++) @(posedge clock);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
